cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Sequences execution of the `computer` top by owning the CPU reset and a clock-enable that gates `cpu_clk`.
- Implements a power-on reset hold, free-run, N-cycle single-step, host halt and re-reset commands.
- Latches the cause of every halt: EBREAK stop, CPU error, watchdog timeout.
- Replaces ad-hoc testbench clock gating; sits between the host/testbench command interface and `computer`.

Parameters:
- RESET_CYCLES, 2: cycles `cpu_reset` is held high after entering INIT (min 1).
- COUNT_W, 16: width of `cmd_count` and the step counter.
- CYCLE_W, 32: width of `cycle_count`.
- MAX_CYCLES, 0: watchdog limit on enabled CPU cycles per run; 0 disables the watchdog.
- ERR_W, 2: width of the packed `CpuError` vector.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  command: 0=RUN, 1=STEP, 2=HALT, 3=RESET.
- cmd_count  in  COUNT_W  cycle count for STEP.
- cpu_stop  in  1  EBREAK stop from CPU.
- cpu_error  in  ERR_W  CpuError vector; nonzero = error.
- cpu_reset  out  1  reset to `computer`.
- cpu_clk_en  out  1  CPU advances on the posedge where this is 1.
- state  out  3  0=INIT, 1=IDLE, 2=RUN, 3=STEP, 4=HALTED.
- halt_cause  out  2  0=NONE, 1=STOP, 2=ERROR, 3=TIMEOUT.
- cycle_count  out  CYCLE_W  enabled CPU cycles since the last INIT exit.

Behaviour:
- Async reset:
  - state=INIT, hold counter=RESET_CYCLES, cycle_count=0, halt_cause=NONE, step counter=0.
  - Outputs during reset: cpu_reset=1, cpu_clk_en=1, cmd_ready=0.
- INIT:
  - cpu_reset=1 and cpu_clk_en=1, so the CPU samples reset.
  - cpu_stop and cpu_error are ignored (suppressed).
  - Hold counter decrements each cycle; on the cycle it reads 1, next state is IDLE.
  - cycle_count is held at 0 throughout.
- cmd_ready = (state != INIT). A command is accepted on a posedge with cmd_valid & cmd_ready.
- IDLE (cpu_clk_en=0):
  - RUN -> RUN.
  - STEP -> STEP, step counter = max(cmd_count, 1).
  - HALT -> no-op.
  - RESET -> INIT.
  - Entering RUN/STEP clears halt_cause to NONE; cycle_count is NOT cleared.
- RUN / STEP:
  - cpu_clk_en = !cpu_stop & (cpu_error == 0), combinational. This blocks the erroring or stopping cycle in the same cycle.
  - An enabled cycle (cpu_clk_en=1 at posedge) increments cycle_count, saturating at all-ones. In STEP it also decrements the step counter.
- Transition priority, highest first, evaluated each posedge in RUN/STEP:
  1. cpu_error != 0 -> HALTED, cause ERROR.
  2. cpu_stop -> HALTED, cause STOP.
  3. MAX_CYCLES != 0 and an enabled cycle makes cycle_count reach MAX_CYCLES -> HALTED, cause TIMEOUT.
  4. Accepted RESET -> INIT.
  5. Accepted HALT -> IDLE, cause NONE.
  6. STEP with step counter == 1 on an enabled cycle -> IDLE, cause NONE.
  - Accepted RUN/STEP while in RUN/STEP: consumed, no effect.
- HALTED:
  - cpu_clk_en=0; halt_cause holds.
  - Only RESET leaves (-> INIT). RUN/STEP/HALT are consumed with no effect.
- Entering INIT from any state:
  - Reload hold counter, clear cycle_count and halt_cause.
  - cpu_reset rises the same cycle the state becomes INIT.
- Mid-operation async reset: immediate INIT regardless of state or outstanding step count.
- cpu_reset is a registered decode of state (no glitches). cpu_clk_en is combinational from state and CPU status.

Test Plan:
- Power-on, RESET_CYCLES=2, no commands -> cpu_reset high for 2 posedges then 0. state INIT->IDLE. cpu_clk_en=0 in IDLE. cpu_error=1 injected during INIT is ignored.
- IDLE, STEP cmd_count=3 -> exactly 3 enabled cycles, then IDLE. cycle_count=3, halt_cause=NONE. STEP with cmd_count=0 gives 1 cycle.
- RUN, cpu_stop raised on the 5th cycle -> cpu_clk_en=0 that same cycle. state=HALTED, halt_cause=STOP, cycle_count=4. A following RUN is ignored; RESET -> INIT with cycle_count=0.
- RUN with cpu_error=2'b10 and cpu_stop=1 on the same cycle -> halt_cause=ERROR (error wins).
- MAX_CYCLES=10, RUN with no stop -> HALTED after 10 enabled cycles, cause TIMEOUT, cycle_count=10.
- RUN, HALT accepted on cycle 7 -> IDLE with cycle_count=7. Assert async reset during a STEP of 100 -> immediate INIT, cpu_reset=1, cmd_ready=0.

Source files
------------

// File: rtl/cpu_run_controller.sv
// Run controller for the `computer` top: owns the CPU reset and the clock-enable,
// sequencing power-on reset, free-run, N-cycle step, host halt and halt-cause capture.
module cpu_run_controller #(
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned COUNT_W      = 16,
    parameter int unsigned CYCLE_W      = 32,
    parameter int unsigned MAX_CYCLES   = 0,
    parameter int unsigned ERR_W        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic               cpu_stop,
    input  logic [ERR_W-1:0]   cpu_error,
    output logic               cpu_reset,
    output logic               cpu_clk_en,
    output logic [2:0]         state,
    output logic [1:0]         halt_cause,
    output logic [CYCLE_W-1:0] cycle_count
);

    localparam int unsigned HoldW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(RESET_CYCLES);

    localparam logic [1:0] OpRun   = 2'd0;
    localparam logic [1:0] OpStep  = 2'd1;
    localparam logic [1:0] OpHalt  = 2'd2;
    localparam logic [1:0] OpReset = 2'd3;

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseStop    = 2'd1;
    localparam logic [1:0] CauseError   = 2'd2;
    localparam logic [1:0] CauseTimeout = 2'd3;

    typedef enum logic [2:0] {
        StInit   = 3'd0,
        StIdle   = 3'd1,
        StRun    = 3'd2,
        StStep   = 3'd3,
        StHalted = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [1:0]         cause_q, cause_d;
    logic [COUNT_W-1:0] step_q, step_d;
    logic               cpu_reset_q;

    logic               cmd_acc;
    logic               cpu_err;
    logic               clk_en;
    logic               timeout;
    logic               go_init;
    logic [CYCLE_W-1:0] cycle_inc;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        cause_d   = cause_q;
        step_d    = step_q;
        go_init   = 1'b0;
        clk_en    = 1'b0;

        cmd_acc   = cmd_valid && (state_q != StInit);
        cpu_err   = |cpu_error;
        cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;

        // The stopping/erroring cycle itself must not advance the CPU.
        unique case (state_q)
            StInit:        clk_en = 1'b1;
            StRun, StStep: clk_en = !cpu_stop && !cpu_err;
            default:       clk_en = 1'b0;
        endcase

        timeout = (MAX_CYCLES != 0) && clk_en && (cycle_inc == CYCLE_W'(MAX_CYCLES));

        case (state_q)
            StInit: begin
                cycle_d = '0;
                if (hold_q == HoldW'(1)) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            StIdle: begin
                if (cmd_acc) begin
                    unique case (cmd_op)
                        OpRun: begin
                            state_d = StRun;
                            cause_d = CauseNone;
                        end
                        OpStep: begin
                            state_d = StStep;
                            cause_d = CauseNone;
                            step_d  = (cmd_count == '0) ? COUNT_W'(1) : cmd_count;
                        end
                        OpReset: go_init = 1'b1;
                        default: ;
                    endcase
                end
            end
            StRun, StStep: begin
                if (clk_en) begin
                    cycle_d = cycle_inc;
                    if (state_q == StStep) begin
                        step_d = step_q - 1'b1;
                    end
                end
                if (cpu_err) begin
                    state_d = StHalted;
                    cause_d = CauseError;
                end else if (cpu_stop) begin
                    state_d = StHalted;
                    cause_d = CauseStop;
                end else if (timeout) begin
                    state_d = StHalted;
                    cause_d = CauseTimeout;
                end else if (cmd_acc && cmd_op == OpReset) begin
                    go_init = 1'b1;
                end else if (cmd_acc && cmd_op == OpHalt) begin
                    state_d = StIdle;
                    cause_d = CauseNone;
                end else if (state_q == StStep && clk_en && step_q == COUNT_W'(1)) begin
                    state_d = StIdle;
                    cause_d = CauseNone;
                end
            end
            StHalted: begin
                if (cmd_acc && cmd_op == OpReset) begin
                    go_init = 1'b1;
                end
            end
            default: go_init = 1'b1;
        endcase

        if (go_init) begin
            state_d = StInit;
            hold_d  = HoldInit;
            cycle_d = '0;
            cause_d = CauseNone;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StInit;
            hold_q      <= HoldInit;
            cycle_q     <= '0;
            cause_q     <= CauseNone;
            step_q      <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cycle_q     <= cycle_d;
            cause_q     <= cause_d;
            step_q      <= step_d;
            cpu_reset_q <= (state_d == StInit);
        end
    end

    assign cmd_ready   = (state_q != StInit);
    assign cpu_reset   = cpu_reset_q;
    assign cpu_clk_en  = clk_en;
    assign state       = state_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller: directed test-plan scenarios followed by
// randomized commands and CPU status, compared each cycle against a behavioural model.
module tb_cpu_run_controller;

    localparam int RC   = 2;
    localparam int MAXC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic        cpu_stop;
    logic [1:0]  cpu_error;
    logic        cpu_reset;
    logic        cpu_clk_en;
    logic [2:0]  state;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0=INIT 1=IDLE 2=RUN 3=STEP 4=HALTED; cause 0..3.
    int m_mode, m_hold, m_cycles, m_steps, m_cause;

    cpu_run_controller #(
        .RESET_CYCLES(RC),
        .COUNT_W     (16),
        .CYCLE_W     (32),
        .MAX_CYCLES  (MAXC),
        .ERR_W       (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .cpu_stop   (cpu_stop),
        .cpu_error  (cpu_error),
        .cpu_reset  (cpu_reset),
        .cpu_clk_en (cpu_clk_en),
        .state      (state),
        .halt_cause (halt_cause),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic m_enter_init();
        m_mode   = 0;
        m_hold   = RC;
        m_cycles = 0;
        m_cause  = 0;
    endtask

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic cycle(input bit v, input int op, input int cnt, input bit stp, input int err);
        bit acc, en, running;
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = 2'(op);
        cmd_count = 16'(cnt);
        cpu_stop  = stp;
        cpu_error = 2'(err);
        #1;
        running = (m_mode == 2) || (m_mode == 3);
        en  = (m_mode == 0) || (running && !stp && err == 0);
        acc = v && (m_mode != 0);
        check_eq("state", state, m_mode);
        check_eq("cpu_reset", cpu_reset, m_mode == 0);
        check_eq("cmd_ready", cmd_ready, m_mode != 0);
        check_eq("cpu_clk_en", cpu_clk_en, en);
        check_eq("halt_cause", halt_cause, m_cause);
        check_eq("cycle_count", cycle_count, m_cycles);

        if (m_mode == 0) begin
            m_cycles = 0;
            if (m_hold == 1) m_mode = 1;
            else m_hold--;
        end else if (m_mode == 1) begin
            if (acc && op == 0) begin
                m_mode = 2; m_cause = 0;
            end else if (acc && op == 1) begin
                m_mode = 3; m_cause = 0; m_steps = (cnt == 0) ? 1 : cnt;
            end else if (acc && op == 3) begin
                m_enter_init();
            end
        end else if (running) begin
            int old_steps = m_steps;
            if (en) begin
                if (m_cycles != 32'hffff_ffff) m_cycles++;
                if (m_mode == 3) m_steps--;
            end
            if (err != 0) begin
                m_mode = 4; m_cause = 2;
            end else if (stp) begin
                m_mode = 4; m_cause = 1;
            end else if (en && m_cycles == MAXC) begin
                m_mode = 4; m_cause = 3;
            end else if (acc && op == 3) begin
                m_enter_init();
            end else if (acc && op == 2) begin
                m_mode = 1; m_cause = 0;
            end else if (m_mode == 3 && en && old_steps == 1) begin
                m_mode = 1; m_cause = 0;
            end
        end else if (m_mode == 4) begin
            if (acc && op == 3) m_enter_init();
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_count = 16'd0;
        cpu_stop = 1'b0; cpu_error = 2'd0;
        m_enter_init();
        m_steps = 0;
        #1;
        check_eq("rst_state", state, 0);
        check_eq("rst_cpu_reset", cpu_reset, 1);
        check_eq("rst_clk_en", cpu_clk_en, 1);
        check_eq("rst_cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Power-on with an error injected during INIT.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        idle_cycles(1);

        // STEP 3, then STEP 0.
        cycle(1, 1, 3, 0, 0);
        idle_cycles(3);
        settle();
        check_eq("step3_state", state, 1);
        check_eq("step3_cycles", cycle_count, 3);
        cycle(1, 1, 0, 0, 0);
        idle_cycles(1);
        settle();
        check_eq("step0_cycles", cycle_count, 4);
        check_eq("step0_state", state, 1);

        // Fresh run, stop on the 5th cycle.
        cycle(1, 3, 0, 0, 0);
        idle_cycles(2);
        cycle(1, 0, 0, 0, 0);
        idle_cycles(4);
        cycle(0, 0, 0, 1, 0);
        settle();
        check_eq("stop_state", state, 4);
        check_eq("stop_cause", halt_cause, 1);
        check_eq("stop_cycles", cycle_count, 4);
        cycle(1, 0, 0, 0, 0);
        settle();
        check_eq("halted_run_ignored", state, 4);
        cycle(1, 3, 0, 0, 0);
        settle();
        check_eq("reset_cmd_state", state, 0);
        check_eq("reset_cmd_cycles", cycle_count, 0);
        idle_cycles(2);

        // Error and stop together: error wins.
        cycle(1, 0, 0, 0, 0);
        idle_cycles(2);
        cycle(0, 0, 0, 1, 2);
        settle();
        check_eq("err_cause", halt_cause, 2);
        cycle(1, 3, 0, 0, 0);
        idle_cycles(2);

        // Watchdog timeout.
        cycle(1, 0, 0, 0, 0);
        idle_cycles(MAXC);
        settle();
        check_eq("to_state", state, 4);
        check_eq("to_cause", halt_cause, 3);
        check_eq("to_cycles", cycle_count, MAXC);
        cycle(1, 3, 0, 0, 0);
        idle_cycles(2);

        // Host HALT on the 7th cycle.
        cycle(1, 0, 0, 0, 0);
        idle_cycles(6);
        cycle(1, 2, 0, 0, 0);
        settle();
        check_eq("halt_state", state, 1);
        check_eq("halt_cycles", cycle_count, 7);

        // Async reset in the middle of a long STEP.
        cycle(1, 1, 100, 0, 0);
        idle_cycles(3);
        cmd_valid = 1'b0; cpu_stop = 1'b0; cpu_error = 2'd0;
        reset = 1'b1;
        #1;
        check_eq("async_state", state, 0);
        check_eq("async_cpu_reset", cpu_reset, 1);
        check_eq("async_cmd_ready", cmd_ready, 0);
        check_eq("async_cycles", cycle_count, 0);
        m_enter_init();
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomized commands and CPU status.
        for (int i = 0; i < 2000; i++) begin
            bit v, stp;
            int op, cnt, err;
            v   = ($urandom_range(0, 99) < 20);
            op  = $urandom_range(0, 3);
            cnt = $urandom_range(0, 5);
            stp = ($urandom_range(0, 99) < 5);
            err = ($urandom_range(0, 99) < 5) ? $urandom_range(1, 3) : 0;
            cycle(v, op, cnt, stp, err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
